// File: rtl/core_pkg.sv
// core_pkg: shared defaults and helpers for the RV32IMAC core.
//   DEFAULT_XLEN     - data/address width
//   DEFAULT_RESET_PC - PC of the first instruction after reset
//   is_compressed()  - true when a halfword starts a 16-bit instruction
package core_pkg;

  localparam int unsigned DEFAULT_XLEN     = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic is_compressed(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/halfword_fifo.sv
// halfword_fifo: DEPTH x 16-bit circular queue feeding the fetch aligner.
// Ports:
//   clk, reset        - clock, asynchronous active-low reset
//   clear             - drop all entries (pointers/count only)
//   push_cnt          - halfwords to push this cycle (0, 1 or 2)
//   push_data         - [15:0] pushed first, [31:16] second
//   pop_cnt           - halfwords to pop this cycle (0, 1 or 2)
//   head_lo, head_hi  - entry at head and head+1
//   count             - number of valid entries (0..DEPTH)
module halfword_fifo #(
  parameter int unsigned DEPTH = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic [1:0]                 push_cnt,
  input  logic [31:0]                push_data,
  input  logic [1:0]                 pop_cnt,
  output logic [15:0]                head_lo,
  output logic [15:0]                head_hi,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [15:0]   mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two).
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
    logic [PW:0] s;
    s = (PW+1)'(p) + (PW+1)'(n);
    if (s >= (PW+1)'(DEPTH)) s = s - (PW+1)'(DEPTH);
    return s[PW-1:0];
  endfunction

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = ptr_add(head_q, pop_cnt);
      tail_d  = ptr_add(tail_q, push_cnt);
      count_d = count_q + CW'(push_cnt) - CW'(pop_cnt);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (!clear && push_cnt != 2'd0) mem_q[tail_q] <= push_data[15:0];
      if (!clear && push_cnt == 2'd2) mem_q[ptr_add(tail_q, 2'd1)] <= push_data[31:16];
    end
  end

  assign head_lo = mem_q[head_q];
  assign head_hi = mem_q[ptr_add(head_q, 2'd1)];
  assign count   = count_q;

endmodule

// File: rtl/fetch_align_queue.sv
// fetch_align_queue: fetches aligned 32-bit words, buffers them as halfwords
// and emits one 16- or 32-bit instruction per valid/ready handshake.
// Ports:
//   clk, reset            - clock, asynchronous active-low reset
//   redirect, redirect_pc - flush and restart fetch at redirect_pc (bit 0 ignored)
//   imem_req/addr/gnt     - word-aligned fetch request channel
//   imem_rvalid/rdata     - in-order response channel
//   instr_valid/ready     - handshake towards the IF/ID register
//   instr, instr_pc       - instruction (compressed ones zero-extended) and its PC
//   instr_compressed      - instr is a 16-bit instruction
module fetch_align_queue
  import core_pkg::*;
#(
  parameter int unsigned     XLEN     = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
  parameter int unsigned     DEPTH    = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_compressed
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] head_pc_q, head_pc_d;
  logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
  logic            outst_q, outst_d;
  logic            discard_q, discard_d;
  logic            drop_q, drop_d;

  logic [15:0]   head_lo, head_hi;
  logic [CW-1:0] count;
  logic          head_comp, grant, accept, take_rsp;
  logic [1:0]    push_cnt, pop_cnt;
  logic [31:0]   push_data;

  halfword_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (redirect),
    .push_cnt (push_cnt),
    .push_data(push_data),
    .pop_cnt  (pop_cnt),
    .head_lo  (head_lo),
    .head_hi  (head_hi),
    .count    (count)
  );

  assign head_comp = is_compressed(head_lo);

  // Redirect masks instr_valid so the flushed head is never consumed.
  assign instr_valid      = !redirect && (head_comp ? (count >= CW'(1)) : (count >= CW'(2)));
  assign instr            = head_comp ? {16'h0000, head_lo} : {head_hi, head_lo};
  assign instr_pc         = head_pc_q;
  assign instr_compressed = (count != '0) && head_comp;

  // Requests only while at most 2 halfwords are queued, so one more word always fits.
  assign imem_req  = reset && !redirect && (!outst_q || imem_rvalid) && (count <= CW'(2));
  assign imem_addr = fetch_addr_q;
  assign grant     = imem_req && imem_gnt;

  assign take_rsp  = imem_rvalid && !discard_q && !redirect;
  assign push_cnt  = !take_rsp ? 2'd0 : (drop_q ? 2'd1 : 2'd2);
  assign push_data = drop_q ? {16'h0000, imem_rdata[31:16]} : imem_rdata;

  assign accept  = instr_valid && instr_ready;
  assign pop_cnt = !accept ? 2'd0 : (head_comp ? 2'd1 : 2'd2);

  always_comb begin
    head_pc_d    = head_pc_q;
    fetch_addr_d = fetch_addr_q;
    outst_d      = outst_q;
    discard_d    = discard_q;
    drop_d       = drop_q;
    if (redirect) begin
      head_pc_d    = {redirect_pc[XLEN-1:1], 1'b0};
      fetch_addr_d = {redirect_pc[XLEN-1:2], 2'b00};
      drop_d       = redirect_pc[1];
      // A response landing in this cycle retires the outstanding request;
      // otherwise the one still in flight is stale and must be skipped.
      outst_d      = outst_q && !imem_rvalid;
      discard_d    = outst_q && !imem_rvalid;
    end else begin
      if (accept) head_pc_d = head_pc_q + (head_comp ? XLEN'(2) : XLEN'(4));
      if (grant) fetch_addr_d = fetch_addr_q + XLEN'(4);
      if (grant) outst_d = 1'b1;
      else if (imem_rvalid) outst_d = 1'b0;
      if (imem_rvalid) begin
        if (discard_q) discard_d = 1'b0;
        else drop_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_pc_q    <= RESET_PC;
      fetch_addr_q <= {RESET_PC[XLEN-1:2], 2'b00};
      outst_q      <= 1'b0;
      discard_q    <= 1'b0;
      drop_q       <= RESET_PC[1];
    end else begin
      head_pc_q    <= head_pc_d;
      fetch_addr_q <= fetch_addr_d;
      outst_q      <= outst_d;
      discard_q    <= discard_d;
      drop_q       <= drop_d;
    end
  end

endmodule

// File: tb/tb_fetch_align_queue.sv
// tb_fetch_align_queue: directed and randomized checks of fetch_align_queue
// against an instruction-stream model that walks program memory by PC.
module tb_fetch_align_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_compressed;

  int checks = 0;
  int failures = 0;
  int grants = 0;

  fetch_align_queue dut (
    .clk             (clk),
    .reset           (reset),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_compressed(instr_compressed)
  );

  always #5 clk = ~clk;

  // Memory model: grant when enabled, respond lat cycles after the grant, in order.
  logic [31:0] mem [0:255];
  logic        gnt_en = 1'b1;
  int          lat = 1;
  logic        pend_q;
  int          cnt_q;
  logic [31:0] addr_q;

  assign imem_gnt    = imem_req && gnt_en;
  assign imem_rvalid = pend_q && (cnt_q == 0);
  assign imem_rdata  = imem_rvalid ? mem[addr_q[9:2]] : 32'h0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= 1'b0;
      cnt_q  <= 0;
      addr_q <= 32'h0;
    end else if (imem_gnt) begin
      pend_q <= 1'b1;
      cnt_q  <= lat - 1;
      addr_q <= imem_addr;
    end else if (imem_rvalid) begin
      pend_q <= 1'b0;
    end else if (pend_q && cnt_q > 0) begin
      cnt_q <= cnt_q - 1;
    end
  end

  always @(posedge clk) if (reset && imem_gnt) grants <= grants + 1;

  // Reference: the instruction at a PC is read straight out of program memory.
  function automatic logic [15:0] ref_hw(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic void ref_next(input logic [31:0] pc, output logic [31:0] ei,
                                   output logic ec, output logic [31:0] npc);
    logic [15:0] h0;
    h0  = ref_hw(pc);
    ec  = (h0[1:0] != 2'b11);
    ei  = ec ? {16'h0, h0} : {ref_hw(pc + 32'd2), h0};
    npc = pc + (ec ? 32'd2 : 32'd4);
  endfunction

  task automatic do_reset();
    reset       = 1'b0;
    redirect    = 1'b0;
    instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic fill_nops();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
  endtask

  task automatic test_reset();
    fill_nops();
    mem[0] = 32'h00A0_0093;
    gnt_en = 1'b1;
    lat    = 1;
    reset  = 1'b0;
    repeat (2) @(negedge clk);
    checks += 5;
    if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    if (instr !== 32'h0) begin failures++; $display("FAIL rst_instr: got %h want 0", instr); end
    if (instr_pc !== 32'h0) begin failures++; $display("FAIL rst_pc: got %h want 0", instr_pc); end
    if (instr_compressed !== 1'b0) begin failures++; $display("FAIL rst_comp: got %b want 0", instr_compressed); end
    if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b want 0", imem_req); end
    reset = 1'b1;
    #1;
    checks += 2;
    if (imem_req !== 1'b1) begin failures++; $display("FAIL c1_req: got %b want 1", imem_req); end
    if (imem_addr !== 32'h0) begin failures++; $display("FAIL c1_addr: got %h want 0", imem_addr); end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0) begin failures++; $display("FAIL c2_valid: got %b want 0", instr_valid); end
    @(negedge clk);
    checks += 4;
    if (instr_valid !== 1'b1) begin failures++; $display("FAIL c3_valid: got %b want 1", instr_valid); end
    if (instr !== 32'h00A0_0093) begin failures++; $display("FAIL c3_instr: got %h want 00a00093", instr); end
    if (instr_pc !== 32'h0) begin failures++; $display("FAIL c3_pc: got %h want 0", instr_pc); end
    if (instr_compressed !== 1'b0) begin failures++; $display("FAIL c3_comp: got %b want 0", instr_compressed); end
  endtask

  task automatic test_compressed_pair();
    logic [31:0] ei [3] = '{32'h0000_4501, 32'h0000_4505, 32'h0000_0093};
    logic [31:0] ep [3] = '{32'h0, 32'h2, 32'h4};
    logic        ec [3] = '{1'b1, 1'b1, 1'b0};
    fill_nops();
    mem[0] = 32'h4505_4501;
    mem[1] = 32'h0000_0093;
    do_reset();
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int t;
      t = 0;
      while (!instr_valid && t < 20) begin @(negedge clk); t++; end
      checks++;
      if (!instr_valid) begin
        failures++; $display("FAIL pair_timeout[%0d]: valid=0 want 1", k);
      end else begin
        checks += 3;
        if (instr !== ei[k]) begin failures++; $display("FAIL pair_instr[%0d]: got %h want %h", k, instr, ei[k]); end
        if (instr_pc !== ep[k]) begin failures++; $display("FAIL pair_pc[%0d]: got %h want %h", k, instr_pc, ep[k]); end
        if (instr_compressed !== ec[k]) begin failures++; $display("FAIL pair_comp[%0d]: got %b want %b", k, instr_compressed, ec[k]); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_straddle();
    logic [31:0] ei [3] = '{32'h0000_4501, 32'h00A0_0093, 32'h0000_4581};
    logic [31:0] ep [3] = '{32'h0, 32'h2, 32'h6};
    logic        ec [3] = '{1'b1, 1'b0, 1'b1};
    fill_nops();
    mem[0] = 32'h0093_4501;
    mem[1] = 32'h4581_00A0;
    do_reset();
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int t;
      t = 0;
      while (!instr_valid && t < 20) begin @(negedge clk); t++; end
      checks++;
      if (!instr_valid) begin
        failures++; $display("FAIL strad_timeout[%0d]: valid=0 want 1", k);
      end else begin
        checks += 3;
        if (instr !== ei[k]) begin failures++; $display("FAIL strad_instr[%0d]: got %h want %h", k, instr, ei[k]); end
        if (instr_pc !== ep[k]) begin failures++; $display("FAIL strad_pc[%0d]: got %h want %h", k, instr_pc, ep[k]); end
        if (instr_compressed !== ec[k]) begin failures++; $display("FAIL strad_comp[%0d]: got %b want %b", k, instr_compressed, ec[k]); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect();
    logic [31:0] ei [2] = '{32'h0000_4581, 32'h00A0_0093};
    logic [31:0] ep [2] = '{32'h102, 32'h104};
    logic        ec [2] = '{1'b1, 1'b0};
    int t;
    fill_nops();
    mem[64] = 32'h4581_1234;
    mem[65] = 32'h00A0_0093;
    lat = 3;
    do_reset();
    @(negedge clk);  // first request granted, response still in flight
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0102;
    #1;
    checks += 2;
    if (instr_valid !== 1'b0) begin failures++; $display("FAIL redir_valid: got %b want 0", instr_valid); end
    if (imem_req !== 1'b0) begin failures++; $display("FAIL redir_req: got %b want 0", imem_req); end
    @(negedge clk);
    redirect = 1'b0;
    lat      = 1;
    t = 0;
    while (!imem_gnt && t < 20) begin @(negedge clk); t++; end
    checks++;
    if (!imem_gnt) begin
      failures++; $display("FAIL redir_grant_timeout: gnt=0 want 1");
    end else begin
      checks++;
      if (imem_addr !== 32'h100) begin failures++; $display("FAIL redir_addr: got %h want 00000100", imem_addr); end
    end
    instr_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      t = 0;
      while (!instr_valid && t < 20) begin @(negedge clk); t++; end
      checks++;
      if (!instr_valid) begin
        failures++; $display("FAIL redir_timeout[%0d]: valid=0 want 1", k);
      end else begin
        checks += 3;
        if (instr !== ei[k]) begin failures++; $display("FAIL redir_instr[%0d]: got %h want %h", k, instr, ei[k]); end
        if (instr_pc !== ep[k]) begin failures++; $display("FAIL redir_pc[%0d]: got %h want %h", k, instr_pc, ep[k]); end
        if (instr_compressed !== ec[k]) begin failures++; $display("FAIL redir_comp[%0d]: got %b want %b", k, instr_compressed, ec[k]); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    logic [31:0] pc, ei, npc;
    logic        ec;
    int          g0, t;
    for (int i = 0; i < 256; i++) mem[i] = {4'h4, 10'(2 * i + 1), 2'b01, 4'h4, 10'(2 * i), 2'b00};
    lat    = 1;
    gnt_en = 1'b1;
    do_reset();
    g0 = grants;
    repeat (10) @(negedge clk);
    checks += 3;
    // Zero-wait fill: three words land before count exceeds 2 at request time.
    if (grants - g0 !== 3) begin failures++; $display("FAIL stall_grants: got %0d want 3", grants - g0); end
    if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_req: got %b want 0", imem_req); end
    if (instr_valid !== 1'b1) begin failures++; $display("FAIL stall_valid: got %b want 1", instr_valid); end
    instr_ready = 1'b1;
    pc = 32'h0;
    for (int k = 0; k < 12; k++) begin
      t = 0;
      while (!instr_valid && t < 20) begin @(negedge clk); t++; end
      checks++;
      if (!instr_valid) begin
        failures++; $display("FAIL stall_timeout[%0d]: valid=0 want 1", k);
      end else begin
        ref_next(pc, ei, ec, npc);
        checks += 2;
        if (instr !== ei) begin failures++; $display("FAIL stall_instr[%0d]: got %h want %h", k, instr, ei); end
        if (instr_pc !== pc) begin failures++; $display("FAIL stall_pc[%0d]: got %h want %h", k, instr_pc, pc); end
        pc = npc;
      end
      @(negedge clk);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 1) == 1) w[1:0] = 2'b11;
      if ($urandom_range(0, 1) == 1) w[17:16] = 2'b11;
      mem[i] = w;
    end
  endtask

  task automatic test_random();
    logic [31:0] pc, ei, npc;
    logic        ec;
    int          acc;
    fill_random();
    lat    = 1;
    gnt_en = 1'b1;
    do_reset();
    pc  = 32'h0;
    acc = 0;
    for (int c = 0; c < 1500; c++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      gnt_en      = ($urandom_range(0, 3) != 0);
      lat         = $urandom_range(1, 3);
      redirect    = ($urandom_range(0, 49) == 0);
      redirect_pc = $urandom;
      #1;
      if (redirect) begin
        checks++;
        if (instr_valid !== 1'b0) begin failures++; $display("FAIL rnd_redir_valid: got %b want 0", instr_valid); end
        pc = {redirect_pc[31:1], 1'b0};
      end else if (instr_valid && instr_ready) begin
        ref_next(pc, ei, ec, npc);
        checks += 3;
        if (instr !== ei) begin failures++; $display("FAIL rnd_instr@%0d: got %h want %h", c, instr, ei); end
        if (instr_pc !== pc) begin failures++; $display("FAIL rnd_pc@%0d: got %h want %h", c, instr_pc, pc); end
        if (instr_compressed !== ec) begin failures++; $display("FAIL rnd_comp@%0d: got %b want %b", c, instr_compressed, ec); end
        pc = npc;
        acc++;
      end
      if (imem_req) begin
        checks++;
        if (imem_addr[1:0] !== 2'b00) begin failures++; $display("FAIL rnd_align@%0d: got %h want word aligned", c, imem_addr); end
      end
      @(negedge clk);
    end
    redirect = 1'b0;
    checks++;
    if (acc < 100) begin failures++; $display("FAIL rnd_progress: got %0d instrs want >= 100", acc); end
  endtask

  task automatic test_reset_midfetch();
    logic [31:0] ei, npc;
    logic        ec;
    int          t;
    fill_random();
    lat    = 3;
    gnt_en = 1'b1;
    do_reset();
    t = 0;
    while (!(instr_valid && !imem_req) && t < 30) begin @(negedge clk); t++; end
    checks++;
    if (!(instr_valid && !imem_req)) begin failures++; $display("FAIL mid_setup: valid=%b req=%b want 1/0", instr_valid, imem_req); end
    reset = 1'b0;
    #1;
    checks += 5;
    if (instr_valid !== 1'b0) begin failures++; $display("FAIL mid_valid: got %b want 0", instr_valid); end
    if (instr !== 32'h0) begin failures++; $display("FAIL mid_instr: got %h want 0", instr); end
    if (instr_pc !== 32'h0) begin failures++; $display("FAIL mid_pc: got %h want 0", instr_pc); end
    if (instr_compressed !== 1'b0) begin failures++; $display("FAIL mid_comp: got %b want 0", instr_compressed); end
    if (imem_req !== 1'b0) begin failures++; $display("FAIL mid_req: got %b want 0", imem_req); end
    @(negedge clk);
    lat         = 1;
    reset       = 1'b1;
    instr_ready = 1'b1;
    t = 0;
    while (!instr_valid && t < 20) begin @(negedge clk); t++; end
    checks++;
    if (!instr_valid) begin
      failures++; $display("FAIL mid_timeout: valid=0 want 1");
    end else begin
      ref_next(32'h0, ei, ec, npc);
      checks += 2;
      if (instr !== ei) begin failures++; $display("FAIL mid_first_instr: got %h want %h", instr, ei); end
      if (instr_pc !== 32'h0) begin failures++; $display("FAIL mid_first_pc: got %h want 0", instr_pc); end
    end
  endtask

  initial begin
    test_reset();
    test_compressed_pair();
    test_straddle();
    test_redirect();
    test_stall();
    test_random();
    test_reset_midfetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_align_queue.md
# fetch_align_queue

Instruction fetch alignment stage for the RV32IMAC core, sitting between the instruction memory port and the IF/ID pipeline register. It fetches aligned 32-bit words, buffers them as halfwords, and emits exactly one instruction per handshake: a 16-bit compressed instruction or a 32-bit instruction, which may straddle two fetch words. Its instruction, PC and valid outputs feed the IF/ID register; a redirect from the branch/jump unit flushes it. Compressed instructions are expanded downstream in ID.

## Interface
- XLEN, 32, data/address width
- RESET_PC, 32'h0000_0000, PC of the first instruction after reset
- DEPTH, 6, queue depth in halfwords (fixed; must stay ≥ 6)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- redirect  in  1  flush and restart at redirect_pc
- redirect_pc  in  XLEN  new PC, bit 0 ignored
- imem_req  out  1  fetch request
- imem_addr  out  XLEN  word-aligned fetch address, bits [1:0] = 0
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid, in order
- imem_rdata  in  32  response word
- instr_valid  out  1  instr / instr_pc valid
- instr_ready  in  1  downstream accepts, driven as !stall
- instr  out  32  instruction; compressed instructions zero-extended in [31:16]
- instr_pc  out  XLEN  PC of instr
- instr_compressed  out  1  instr[1:0] != 2'b11

## Operation
- Storage is a circular halfword queue: DEPTH × 16 entries, head and tail pointers, count_q (0..DEPTH), and head_pc_q.
- Each halfword of a response enters in order, low half first. When drop_q is set, the low half is discarded and drop_q clears.
- A head halfword with bits [1:0] != 11 is compressed:
  - instr_valid = 1 when count_q ≥ 1.
  - Consumption pops 1 entry and adds 2 to head_pc_q.
- Otherwise the head is a 32-bit instruction:
  - instr_valid = 1 when count_q ≥ 2.
  - instr = {entry[head+1], entry[head]}.
  - Consumption pops 2 entries and adds 4 to head_pc_q.
- Consumption happens when instr_valid && instr_ready.
- Fetch side:
  - imem_req = !redirect && (!outst_q || imem_rvalid) && count_q ≤ 2.
  - outst_q sets on imem_req && imem_gnt. It clears on imem_rvalid unless a new grant occurs in the same cycle.
  - fetch_addr_q advances by 4 on each grant.
- Redirect has priority over everything else in its cycle:
  - Clear the queue.
  - Set head_pc_q = {redirect_pc[31:1], 0}, fetch_addr_q = {redirect_pc[31:2], 00}, drop_q = redirect_pc[1].
  - instr_valid is forced to 0.
  - If a request is outstanding, set discard_q. The next imem_rvalid is then dropped and discard_q clears.
  - A response arriving in the redirect cycle itself is dropped.
- Simultaneous push and pop in one cycle are allowed. count_next = count_q + pushed − popped.
- Reset values:
  - count_q = 0, outst_q = 0, discard_q = 0, drop_q = RESET_PC[1].
  - head_pc_q = RESET_PC, fetch_addr_q = RESET_PC & ~3.
  - Entries = 0, so instr_valid = 0, instr = 0, instr_pc = RESET_PC, instr_compressed = 0 while the queue is empty.
  - imem_req = 0 while reset is asserted. It is 1 in the first cycle after release.
- Assertion of reset mid-fetch discards everything, including an outstanding response.

## Timing
- Outputs instr, instr_pc, instr_valid and instr_compressed are combinational from registers only. There is no path from instr_ready or imem_* to them.
- Redirect in cycle N gives imem_req at N+1. With zero-wait memory (gnt at N+1, rvalid at N+2), instr_valid rises at N+3.
- Steady state with zero-wait memory and instr_ready = 1 sustains one 32-bit instruction per cycle. Compressed code builds up the queue and throttles requests through count_q ≤ 2.
- Overflow is impossible: at most 2 halfwords are in flight when count_q ≤ 2 at grant time, and DEPTH = 6.
- PC arithmetic wraps modulo 2^XLEN.

## Structure
- core_pkg holds:
  - XLEN and RESET_PC defaults.
  - A function is_compressed(hw) returning hw[1:0] != 2'b11.
- One sub-module, halfword_fifo: DEPTH × 16 circular storage with push-1/push-2 and pop-1/pop-2 ports, and a count output.
- fetch_align_queue holds the fetch/redirect control and the PC tracking.

## Test plan
- Reset, zero-wait memory returning 32'h00A00093 at address 0 → imem_addr = 0 at cycle 1; instr = 32'h00A00093, instr_pc = 0, instr_compressed = 0 at cycle 3.
- Words 32'h4505_4501, 32'h0000_0093 → instr 0x4501 @0 compressed, 0x4505 @2 compressed, 0x00000093 @4.
- Straddle: word@0 = 32'h0093_4501, word@4 = 32'h4581_00A0 → 0x4501 @0, then 0x00A00093 @2 (32-bit), then 0x4581 @6.
- redirect_pc = 32'h0000_0102 with a response outstanding → stale response dropped; imem_addr = 0x100; low half of the word discarded; first instr_pc = 0x102.
- instr_ready = 0 for 10 cycles with compressed-only code → count_q saturates ≤ 6, no requests while count_q > 2; on release, instructions emitted in order with no loss or duplication.
- Reset asserted while outst_q = 1 → all outputs return to reset values immediately; the late rvalid after release is ignored only if it belongs to the pre-reset request (bench: memory model also reset, no rvalid).
